// File: rtl/if_fetch_queue_pkg.sv
// if_fetch_queue_pkg: shared constants for the fetch queue.
// Contents: data/PC width, the pre-decoded opcodes, the queue FSM state
// encoding, and a helper that classifies conditional branches.
// Optional feature macro: IF_BTFN_PREDICT_EN (used by fq_predecode).
package if_fetch_queue_pkg;

  localparam int WORD = 32;

  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BNE  = 6'h17;
  localparam logic [5:0] OP_BLT  = 6'h18;
  localparam logic [5:0] OP_BGE  = 6'h19;
  localparam logic [5:0] OP_BLTU = 6'h1a;
  localparam logic [5:0] OP_BGEU = 6'h1b;

  typedef enum logic {
    FQ_NORMAL = 1'b0,
    FQ_SQUASH = 1'b1
  } fq_state_e;

  function automatic logic is_cond_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) ||
           (op == OP_BGE) || (op == OP_BLTU) || (op == OP_BGEU);
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: handshake and data bundle around the fetch queue.
// Signals:
//   icache_valid/ready/pc/inst  ICache response into the queue
//   id_valid/ready/pc/inst      head entry towards ID
//   id_pre_taken/pre_target     static prediction attached to the head entry
//   redirect_valid/pc           one-cycle redirect to the PC generator
// Modports: slave = the queue itself, master = the surrounding pipeline.
interface if_fetch_queue_if #(
  parameter int WORD = if_fetch_queue_pkg::WORD
);
  logic            icache_valid;
  logic            icache_ready;
  logic [WORD-1:0] icache_pc;
  logic [WORD-1:0] icache_inst;
  logic            id_valid;
  logic            id_ready;
  logic [WORD-1:0] id_pc;
  logic [WORD-1:0] id_inst;
  logic            id_pre_taken;
  logic [WORD-1:0] id_pre_target;
  logic            redirect_valid;
  logic [WORD-1:0] redirect_pc;

  modport slave (
    input  icache_valid, icache_pc, icache_inst, id_ready,
    output icache_ready, id_valid, id_pc, id_inst, id_pre_taken,
           id_pre_target, redirect_valid, redirect_pc
  );

  modport master (
    output icache_valid, icache_pc, icache_inst, id_ready,
    input  icache_ready, id_valid, id_pc, id_inst, id_pre_taken,
           id_pre_target, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/if_fetch_queue_predecode.sv
// fq_predecode: static branch prediction on a single fetched word.
// Ports:
//   inst, pc  fetched instruction and its PC
//   pred_en   global prediction enable (0 forces not taken)
//   taken     word is predicted taken
//   target    predicted target, PC+4 when not taken
// B/BL are always taken. With IF_BTFN_PREDICT_EN defined, backward
// conditional branches are also taken (backward-taken/forward-not-taken);
// otherwise conditional branches are never taken and their adder is absent.
module fq_predecode #(
  parameter int WORD = if_fetch_queue_pkg::WORD
) (
  input  logic [WORD-1:0] inst,
  input  logic [WORD-1:0] pc,
  input  logic            pred_en,
  output logic            taken,
  output logic [WORD-1:0] target
);
  import if_fetch_queue_pkg::*;

  logic [5:0]      op;
  logic [25:0]     offs26;
  logic [WORD-1:0] seq_pc;
  logic [WORD-1:0] tgt_b;

  assign op     = inst[31:26];
  // B/BL scatter their 26-bit offset: low 16 bits in [25:10], high 10 in [9:0].
  assign offs26 = {inst[9:0], inst[25:10]};
  assign seq_pc = pc + WORD'(4);
  assign tgt_b  = pc + {{(WORD-28){offs26[25]}}, offs26, 2'b00};

`ifdef IF_BTFN_PREDICT_EN
  logic [WORD-1:0] tgt_c;
  assign tgt_c = pc + {{(WORD-18){inst[25]}}, inst[25:10], 2'b00};
`endif

  always_comb begin
    taken  = 1'b0;
    target = seq_pc;
    if (pred_en) begin
      case (op)
        OP_B, OP_BL: begin
          taken  = 1'b1;
          target = tgt_b;
        end
        OP_JIRL: begin
          // register-indirect target is unknown at fetch
          taken  = 1'b0;
        end
        default: begin
`ifdef IF_BTFN_PREDICT_EN
          if (is_cond_branch(op) && inst[25]) begin
            taken  = 1'b1;
            target = tgt_c;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch queue with static pre-decode prediction.
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   flush      backend flush, clears queue/FSM/pending redirect next cycle
//   pred_en    global prediction enable
//   bus        if_fetch_queue_if.slave (ICache in, ID out, redirect out)
// Words are pre-decoded as they are accepted; a predicted-taken word raises a
// registered redirect and squashes following wrong-path words.
// Optional feature macro: IF_BTFN_PREDICT_EN (see fq_predecode).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// FQ_NORMAL | every accepted word is enqueued
// FQ_SQUASH | accepted words are dropped until pc == target_r arrives
module if_fetch_queue #(
  parameter int WORD  = if_fetch_queue_pkg::WORD,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic               pred_en,
  if_fetch_queue_if.slave    bus
);
  import if_fetch_queue_pkg::*;

  logic [WORD-1:0] pc_mem    [DEPTH];
  logic [WORD-1:0] inst_mem  [DEPTH];
  logic [WORD-1:0] tgt_mem   [DEPTH];
  logic            taken_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  fq_state_e       state, state_nx;
  logic [WORD-1:0] target_r, target_nx;
  logic            redirect_valid_r, redirect_valid_nx;
  logic [WORD-1:0] redirect_pc_r, redirect_pc_nx;

  logic            ready;
  logic            head_valid;
  logic            accept;
  logic            deq;
  logic            on_path;
  logic            enq;
  logic            pd_taken;
  logic [WORD-1:0] pd_target;

  fq_predecode #(.WORD(WORD)) u_predecode (
    .inst    (bus.icache_inst),
    .pc      (bus.icache_pc),
    .pred_en (pred_en),
    .taken   (pd_taken),
    .target  (pd_target)
  );

  // Readiness depends only on occupancy, so ID never reaches the ICache.
  assign ready      = (count != (PTR_W+1)'(DEPTH));
  assign head_valid = (count != '0);
  assign accept     = bus.icache_valid & ready;
  assign deq        = head_valid & bus.id_ready;
  assign on_path    = (state == FQ_NORMAL) || (bus.icache_pc == target_r);
  assign enq        = accept & on_path & ~flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        inst_mem[i]  <= '0;
        tgt_mem[i]   <= '0;
        taken_mem[i] <= 1'b0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        pc_mem[wr_ptr]    <= bus.icache_pc;
        inst_mem[wr_ptr]  <= bus.icache_inst;
        tgt_mem[wr_ptr]   <= pd_target;
        taken_mem[wr_ptr] <= pd_taken;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= FQ_NORMAL;
      target_r         <= '0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
    end else begin
      state            <= state_nx;
      target_r         <= target_nx;
      redirect_valid_r <= redirect_valid_nx;
      redirect_pc_r    <= redirect_pc_nx;
    end
  end

  always_comb begin
    state_nx          = state;
    target_nx         = target_r;
    redirect_valid_nx = 1'b0;
    redirect_pc_nx    = redirect_pc_r;
    if (flush) begin
      state_nx = FQ_NORMAL;
    end else if (enq) begin
      // The word ending a squash is itself predicted and may start a new one.
      if (pd_taken) begin
        state_nx          = FQ_SQUASH;
        target_nx         = pd_target;
        redirect_valid_nx = 1'b1;
        redirect_pc_nx    = pd_target;
      end else begin
        state_nx = FQ_NORMAL;
      end
    end
  end

  assign bus.icache_ready   = ready;
  assign bus.id_valid       = head_valid;
  assign bus.id_pc          = pc_mem[rd_ptr];
  assign bus.id_inst        = inst_mem[rd_ptr];
  assign bus.id_pre_taken   = taken_mem[rd_ptr];
  assign bus.id_pre_target  = tgt_mem[rd_ptr];
  assign bus.redirect_valid = redirect_valid_r;
  assign bus.redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  localparam logic [31:0] BASE  = 32'h1c00_0000;
  localparam logic [31:0] B_OP  = 32'h5000_4000; // B, offs26 = +0x40 bytes
  localparam logic [31:0] BEQ_N = 32'h5bff_f800; // BEQ, offs16 = -8 bytes

`ifdef IF_BTFN_PREDICT_EN
  localparam logic BTFN = 1'b1;
`else
  localparam logic BTFN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  logic pred_en = 1'b1;

  if_fetch_queue_if #(.WORD(32)) fq_bus ();

  if_fetch_queue dut (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (flush),
    .pred_en (pred_en),
    .bus     (fq_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        id_ready;
    logic        pe;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_taken;
    logic [31:0] e_tgt;
    logic        e_rv;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] nop(input int k);
    return 32'h0280_0000 + 32'(k);
  endfunction

  task automatic add(input logic valid, input logic [31:0] pc, input logic [31:0] inst,
                     input logic idr, input logic pe, input logic e_ready, input logic e_valid,
                     input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_taken,
                     input logic [31:0] e_tgt, input logic e_rv, input logic [31:0] e_rpc);
    vec_t v;
    v.valid = valid; v.pc = pc; v.inst = inst; v.id_ready = idr; v.pe = pe;
    v.e_ready = e_ready; v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst;
    v.e_taken = e_taken; v.e_tgt = e_tgt; v.e_rv = e_rv; v.e_rpc = e_rpc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // drive inputs mid-cycle; outputs checked afterwards reflect the last edge
  task automatic tick(input logic valid, input logic [31:0] pc, input logic [31:0] inst,
                      input logic idr, input logic pe, input logic fl);
    @(negedge clk);
    fq_bus.icache_valid = valid;
    fq_bus.icache_pc    = pc;
    fq_bus.icache_inst  = inst;
    fq_bus.id_ready     = idr;
    pred_en             = pe;
    flush               = fl;
    #1;
  endtask

  task automatic chk_head(input string nm, input logic [31:0] pc, input logic [31:0] inst,
                          input logic taken, input logic [31:0] tgt);
    chk({nm, " id_valid"}, 32'(fq_bus.id_valid), 32'd1);
    chk({nm, " id_pc"}, fq_bus.id_pc, pc);
    chk({nm, " id_inst"}, fq_bus.id_inst, inst);
    chk({nm, " pre_taken"}, 32'(fq_bus.id_pre_taken), 32'(taken));
    chk({nm, " pre_target"}, fq_bus.id_pre_target, tgt);
  endtask

  initial begin
    fq_bus.icache_valid = 1'b0;
    fq_bus.icache_pc    = '0;
    fq_bus.icache_inst  = '0;
    fq_bus.id_ready     = 1'b0;

    // sequential fill with ID stalled, then in-order drain
    add(1, BASE+'h00, nop(0), 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, BASE+'h04, nop(1), 0, 1, 1, 1, BASE+'h00, nop(0), 0, BASE+'h04, 0, 0);
    add(1, BASE+'h08, nop(2), 0, 1, 1, 1, BASE+'h00, nop(0), 0, BASE+'h04, 0, 0);
    add(1, BASE+'h0c, nop(3), 0, 1, 1, 1, BASE+'h00, nop(0), 0, BASE+'h04, 0, 0);
    add(1, BASE+'h10, nop(4), 0, 1, 0, 1, BASE+'h00, nop(0), 0, BASE+'h04, 0, 0);
    add(0, 0, 0,              1, 1, 0, 1, BASE+'h00, nop(0), 0, BASE+'h04, 0, 0);
    add(0, 0, 0,              1, 1, 1, 1, BASE+'h04, nop(1), 0, BASE+'h08, 0, 0);
    add(0, 0, 0,              1, 1, 1, 1, BASE+'h08, nop(2), 0, BASE+'h0c, 0, 0);
    add(0, 0, 0,              1, 1, 1, 1, BASE+'h0c, nop(3), 0, BASE+'h10, 0, 0);
    add(0, 0, 0,              0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // taken B: redirect, squash 0x14/0x18, resume at 0x50
    add(1, BASE+'h10, B_OP,   1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, BASE+'h14, nop(5), 1, 1, 1, 1, BASE+'h10, B_OP, 1, BASE+'h50, 1, BASE+'h50);
    add(1, BASE+'h18, nop(6), 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, BASE+'h50, nop(7), 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, BASE+'h54, nop(8), 1, 1, 1, 1, BASE+'h50, nop(7), 0, BASE+'h54, 0, 0);
    add(0, 0, 0,              1, 1, 1, 1, BASE+'h54, nop(8), 0, BASE+'h58, 0, 0);
    add(0, 0, 0,              0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // same B with prediction disabled
    add(1, BASE+'h10, B_OP,   1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, BASE+'h14, nop(9), 1, 0, 1, 1, BASE+'h10, B_OP, 0, BASE+'h14, 0, 0);
    add(0, 0, 0,              1, 0, 1, 1, BASE+'h14, nop(9), 0, BASE+'h18, 0, 0);
    add(0, 0, 0,              0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // backward BEQ
    add(1, BASE+'h100, BEQ_N, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,              1, 1, 1, 1, BASE+'h100, BEQ_N, BTFN,
        BTFN ? BASE+'hf8 : BASE+'h104, BTFN, BASE+'hf8);
    add(1, BASE+'hf8, nop(10), 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,              1, 1, 1, 1, BASE+'hf8, nop(10), 0, BASE+'hfc, 0, 0);
    add(0, 0, 0,              0, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    #12;
    // reset values while rstn is held low
    chk("rst icache_ready", 32'(fq_bus.icache_ready), 32'd1);
    chk("rst id_valid", 32'(fq_bus.id_valid), 32'd0);
    chk("rst redirect_valid", 32'(fq_bus.redirect_valid), 32'd0);
    chk("rst redirect_pc", fq_bus.redirect_pc, 32'd0);
    chk("rst id_pc", fq_bus.id_pc, 32'd0);
    chk("rst id_inst", fq_bus.id_inst, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      tick(tbl[i].valid, tbl[i].pc, tbl[i].inst, tbl[i].id_ready, tbl[i].pe, 1'b0);
      chk({nm, " icache_ready"}, 32'(fq_bus.icache_ready), 32'(tbl[i].e_ready));
      chk({nm, " redirect_valid"}, 32'(fq_bus.redirect_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk({nm, " redirect_pc"}, fq_bus.redirect_pc, tbl[i].e_rpc);
      if (tbl[i].e_valid)
        chk_head(nm, tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_taken, tbl[i].e_tgt);
      else
        chk({nm, " id_valid"}, 32'(fq_bus.id_valid), 32'd0);
    end

    // flush in the same cycle a B is accepted, with 3 entries queued
    tick(1, BASE+'h200, nop(20), 0, 1, 0);
    tick(1, BASE+'h204, nop(21), 0, 1, 0);
    tick(1, BASE+'h208, nop(22), 0, 1, 0);
    tick(1, BASE+'h20c, B_OP, 0, 1, 1);
    chk_head("fl pre", BASE+'h200, nop(20), 0, BASE+'h204);
    chk("fl pre icache_ready", 32'(fq_bus.icache_ready), 32'd1);
    tick(1, BASE+'h210, nop(23), 0, 1, 0);
    chk("fl id_valid", 32'(fq_bus.id_valid), 32'd0);
    chk("fl redirect_valid", 32'(fq_bus.redirect_valid), 32'd0);
    chk("fl icache_ready", 32'(fq_bus.icache_ready), 32'd1);
    tick(0, 0, 0, 1, 1, 0);
    chk_head("fl post", BASE+'h210, nop(23), 0, BASE+'h214);
    chk("fl post redirect_valid", 32'(fq_bus.redirect_valid), 32'd0);
    tick(0, 0, 0, 0, 1, 0);
    chk("fl drained", 32'(fq_bus.id_valid), 32'd0);

    // full queue: accept attempt together with a dequeue
    for (int k = 0; k < 4; k++) tick(1, BASE+'h300+32'(4*k), nop(30+k), 0, 1, 0);
    tick(1, BASE+'h310, nop(34), 1, 1, 0);
    chk("full icache_ready", 32'(fq_bus.icache_ready), 32'd0);
    chk_head("full", BASE+'h300, nop(30), 0, BASE+'h304);
    for (int k = 1; k < 4; k++) begin
      tick(0, 0, 0, 1, 1, 0);
      chk($sformatf("full drain%0d icache_ready", k), 32'(fq_bus.icache_ready), 32'd1);
      chk_head($sformatf("full drain%0d", k), BASE+'h300+32'(4*k), nop(30+k), 0,
               BASE+'h304+32'(4*k));
    end
    tick(0, 0, 0, 0, 1, 0);
    chk("full count3", 32'(fq_bus.id_valid), 32'd0);

    // async reset while squashing
    tick(1, BASE+'h400, B_OP, 0, 1, 0);
    @(posedge clk);
    #1;
    fq_bus.icache_valid = 1'b0;
    chk("sq redirect_valid", 32'(fq_bus.redirect_valid), 32'd1);
    chk("sq redirect_pc", fq_bus.redirect_pc, BASE+'h440);
    chk("sq id_valid", 32'(fq_bus.id_valid), 32'd1);
    rstn = 1'b0;
    #1;
    chk("arst id_valid", 32'(fq_bus.id_valid), 32'd0);
    chk("arst redirect_valid", 32'(fq_bus.redirect_valid), 32'd0);
    chk("arst redirect_pc", fq_bus.redirect_pc, 32'd0);
    chk("arst icache_ready", 32'(fq_bus.icache_ready), 32'd1);
    chk("arst id_pc", fq_bus.id_pc, 32'd0);
    chk("arst pre_target", fq_bus.id_pre_target, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick(1, BASE+'h404, nop(40), 0, 1, 0);
    tick(0, 0, 0, 1, 1, 0);
    chk_head("arst normal", BASE+'h404, nop(40), 0, BASE+'h408);
    tick(0, 0, 0, 0, 1, 0);
    chk("arst drained", 32'(fq_bus.id_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised successor of the IF1 fetch stage. Sits between the ICache response and ID.
- Buffers fetched instructions in a DEPTH-entry FIFO and performs static pre-decode branch prediction on each enqueued word.
- Issues a registered redirect to the PC generator and squashes wrong-path words until the predicted target arrives.
- Backend flush clears all state.

Parameters:
- WORD, 32, data/PC width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width.

Ports:
- clk  in  1  single clock
- rstn  in  1  asynchronous active-low reset
- flush  in  1  backend flush (mispredict/exception); highest priority
- pred_en  in  1  global prediction enable
- icache_valid  in  1  ICache response valid
- icache_ready  out  1  queue can accept this cycle
- icache_pc  in  WORD  PC of returned word
- icache_inst  in  WORD  returned instruction
- id_valid  out  1  head entry valid
- id_ready  in  1  ID consumes head
- id_pc  out  WORD  head PC
- id_inst  out  WORD  head instruction
- id_pre_taken  out  1  head predicted taken
- id_pre_target  out  WORD  head predicted target (PC+4 when not taken)
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  WORD  redirect target

Behaviour:
- Reset values: all entries invalid, count=0, state=NORMAL. id_valid=0, redirect_valid=0, redirect_pc=0, icache_ready=1. id_* data outputs are 0.
- icache_ready = (count != DEPTH). It does not depend on id_ready, so there is no combinational path from ID to the ICache.
- Accept = icache_valid & icache_ready. Dequeue = id_valid & id_ready. Simultaneous accept and dequeue leaves count unchanged. Pointers wrap modulo DEPTH.
- Pre-decode of opcode inst[31:26], applied at accept:
  - 0x14 B and 0x15 BL: taken; target = pc + sext({inst[9:0],inst[25:10]},2'b00).
  - 0x16 to 0x1B (conditional branches): not taken without the optional feature.
  - JIRL 0x13 and all other opcodes: not taken.
  - pred_en=0 forces not taken.
  - Add wraps modulo 2^WORD.
- States:
  - NORMAL: an accepted word is enqueued. If it is predicted taken, state goes to SQUASH, target_r latches its target, and redirect_valid=1 / redirect_pc=target on the next cycle only.
  - SQUASH: accepted words with pc != target_r are discarded; the handshake still completes and count is unchanged. The first accepted word with pc == target_r is enqueued, state returns to NORMAL, and that word is itself pre-decoded, so it may immediately re-enter SQUASH.
- flush: synchronous. Next cycle count=0, state=NORMAL, redirect_valid=0, and any pending redirect is cancelled. An accept or redirect in the same cycle as flush is discarded. icache_ready remains count-based during the flush cycle.
- Full: no accept. A predicted-taken word already enqueued keeps its SQUASH state.
- Empty: id_valid=0. There is no bypass; minimum ICache-to-ID latency is 1 cycle.
- rstn deassertion mid-operation: asynchronous clear to reset values regardless of state.

Optional Feature:
- Macro: IF_BTFN_PREDICT_EN.
- Defined: conditional branches 0x16 to 0x1B with negative offset (inst[25]=1) are predicted taken, with target = pc + sext(inst[25:10],2'b00). Forward conditional branches are not taken.
- Undefined: conditional branches are always predicted not taken, and the offs16 adder is not built.

Decomposition:
- Shared package/header (CPU parameter include) holds:
  - opcode constants OP_B, OP_BL, OP_BEQ to OP_BGEU, OP_JIRL;
  - state encoding FQ_NORMAL/FQ_SQUASH;
  - WORD.
- One natural combinational sub-module, fq_predecode: inputs inst, pc, pred_en; outputs taken, target. It is reused by future multi-issue variants.
- FIFO storage, pointers and the FSM stay in the top module.

Test Plan:
- Reset then 5 sequential non-branch words at 0x1c000000, with id_ready=0 -> 4 accepted, icache_ready=0 on the 5th. Release id_ready -> in-order output with pre_taken=0 and pre_target=pc+4.
- B at pc 0x1c000010 with offs26=+0x40 -> redirect_valid pulses one cycle later with redirect_pc=0x1c000050. Words at 0x1c000014 and 0x1c000018 are dropped; 0x1c000050 is enqueued; state returns to NORMAL.
- Same B with pred_en=0 -> no redirect; pre_taken=0; following words enqueued.
- BEQ at 0x1c000100 with offs16=-8 -> with IF_BTFN_PREDICT_EN, redirect to 0x1c0000f8; without it, no redirect and pre_target=0x1c000104.
- flush asserted in the same cycle a B is accepted, queue holding 3 entries -> next cycle id_valid=0, count=0, no redirect pulse, state NORMAL.
- Full queue with simultaneous accept-attempt and dequeue -> no accept that cycle; icache_ready=1 the next cycle; count=3 afterwards. Async rstn pulse mid-SQUASH -> immediate return to reset values.
